muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and result width; any value 8..64.
REQ-002 SHALL have parameter TAG_W, default 5: width of the sideband tag (destination register index), carried unmodified.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  in  1  request present.
REQ-006 SHALL have port in_ready  out  1  unit can accept a request.
REQ-007 SHALL have port op  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 SHALL have port a  in  XLEN  rs1 operand.
REQ-009 SHALL have port b  in  XLEN  rs2 operand.
REQ-010 SHALL have port tag_in  in  TAG_W  request tag.
REQ-011 SHALL have port flush  in  1  synchronous abort of any in-flight operation.
REQ-012 SHALL have port out_valid  out  1  result present.
REQ-013 SHALL have port out_ready  in  1  consumer accepts the result.
REQ-014 SHALL have port result  out  XLEN  operation result.
REQ-015 SHALL have port tag_out  out  TAG_W  tag of the request that produced result.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY and DONE; in_ready = (state==IDLE) && !flush.
REQ-017 SHALL accept a request when in_valid && in_ready, latching op, operand magnitudes, operand signs and tag_in in that cycle.
REQ-018 SHALL treat a as signed for MULH, MULHSU, DIV and REM, and b as signed for MULH, DIV and REM; all other operands are unsigned.
REQ-019 SHALL compute multiplies by iterative shift-add on magnitudes over 2*XLEN bits, then negate the product if the operand signs differ.
REQ-020 SHALL return the low XLEN product bits for MUL and the high XLEN bits for MULH, MULHSU and MULHU.
REQ-021 SHALL compute divides by iterative restoring division on magnitudes: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-022 SHALL use the fast path for divide by zero (b==0): DIV/DIVU return all ones, REM/REMU return a.
REQ-023 SHALL use the fast path for signed overflow (DIV/REM, a = most-negative value, b = all ones): DIV returns a, REM returns 0.
REQ-024 SHALL, on the fast path, go IDLE->DONE so that out_valid asserts in the cycle after accept.
REQ-025 SHALL, on the normal path, go IDLE->BUSY and stay in BUSY for exactly XLEN cycles, counted by a counter of clog2(XLEN)+1 bits.
REQ-026 SHALL go BUSY->DONE with sign correction applied, so that out_valid first asserts XLEN+1 cycles after the accept cycle.
REQ-027 SHALL, in DONE, hold out_valid=1 and keep result and tag_out stable until out_valid && out_ready; it then goes to IDLE in the next cycle.
REQ-028 SHALL NOT accept a new request in the cycle in which a result is consumed; accept is possible no earlier than the following cycle.
REQ-029 SHALL, when flush=1 in any state, go to IDLE in the next cycle with out_valid=0; the discarded result is never presented.
REQ-030 SHALL give flush priority over in_valid in the same cycle: no request is accepted.
REQ-031 SHALL hold result and tag_out at their last values whenever out_valid=0; consumers ignore them.
REQ-032 SHALL ignore op, a, b and tag_in while not in IDLE.

Reset
REQ-033 SHALL, on rst_n low and regardless of the clock, force state=IDLE, counter=0, out_valid=0, result=0 and tag_out=0; in_ready then reads 1.
REQ-034 SHALL discard any in-flight operation when reset is asserted mid-operation; after release the unit accepts on the first clock edge.

Verification (XLEN=32)
REQ-035 SHALL cover: MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> result 0xFFFFFFFE; out_valid at accept+33. MUL with the same operands -> 0x00000001.
REQ-036 SHALL cover: DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 at accept+1; REM with the same operands -> 0x00000000 at accept+1.
REQ-037 SHALL cover: DIVU a=5, b=0 -> 0xFFFFFFFF and REMU a=7, b=0 -> 0x00000007, each at accept+1 with tag_out equal to tag_in.
REQ-038 SHALL cover: DIV a=-7, b=2 -> 0xFFFFFFFD; REM a=-7, b=2 -> 0xFFFFFFFF; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
REQ-039 SHALL cover: out_ready held low for 5 cycles after out_valid -> result and tag_out stable and in_ready=0 throughout; out_ready=1 -> in_ready=1 in the next cycle.
REQ-040 SHALL cover: flush in the 10th BUSY cycle -> out_valid never asserts and in_ready=1 in the next cycle; rst_n pulsed low mid-BUSY -> outputs zero immediately and a new DIVU 100/7 -> 0x0000000E.

Source files
------------

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit with tag sideband
// Shift-add multiply and restoring divide on magnitudes, one bit per cycle.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   mag_b;
  logic [2*XLEN-1:0] acc;
  logic              neg_q;
  logic              sign_a;
  logic [TAG_W-1:0]  tag_q;

  assign in_ready = (state == IDLE) && !flush;

  logic            a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] fast_res;

  assign a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  assign b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign sa       = a_signed && a[XLEN-1];
  assign sb       = b_signed && b[XLEN-1];
  assign abs_a    = sa ? -a : a;
  assign abs_b    = sb ? -b : b;
  assign div_zero = op[2] && (b == '0);
  assign div_ovf  = op[2] && !op[0] && (a == MIN_NEG) && (b == '1);
  // op[1] separates REM/REMU from DIV/DIVU on the divide side
  assign fast_res = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);

  // One iteration of each algorithm; acc holds {partial, multiplier/quotient}
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] mul_nx, div_nx, acc_nx, mul_fix;
  logic [XLEN-1:0]   q_raw, r_raw, q_fix, r_fix, final_res;

  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mag_b : '0)};
  assign mul_nx   = {mul_sum, acc[XLEN-1:1]};
  assign div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_diff = div_sh - {1'b0, mag_b};
  assign div_nx   = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  assign acc_nx   = op_q[2] ? div_nx : mul_nx;

  assign mul_fix  = neg_q ? -acc_nx : acc_nx;
  assign q_raw    = acc_nx[XLEN-1:0];
  assign r_raw    = acc_nx[2*XLEN-1:XLEN];
  assign q_fix    = neg_q ? -q_raw : q_raw;
  assign r_fix    = sign_a ? -r_raw : r_raw;
  assign final_res = op_q[2] ? (op_q[1] ? r_fix : q_fix)
                             : ((op_q[1:0] == 2'b00) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      mag_b     <= '0;
      acc       <= '0;
      neg_q     <= 1'b0;
      sign_a    <= 1'b0;
      tag_q     <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      tag_out   <= '0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q   <= op;
            tag_q  <= tag_in;
            neg_q  <= sa ^ sb;
            sign_a <= sa;
            mag_b  <= abs_b;
            acc    <= {{XLEN{1'b0}}, abs_a};
            cnt    <= '0;
            if (div_zero || div_ovf) begin
              result    <= fast_res;
              tag_out   <= tag_in;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          acc <= acc_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN - 1)) begin
            result    <= final_res;
            tag_out   <= tag_q;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
`timescale 1ns/1ps
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  tag_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  tag_out;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .tag_in(tag_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] ia,
                        input logic [31:0] ib, input logic [4:0] t,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    op = o; a = ia; b = ib; tag_in = t; in_valid = 1'b1;
    #1;
    check({name, " in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom; tag_in = 5'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 80);
    check({name, " latency"}, lat, exp_lat);
    check({name, " result"}, result, exp);
    check({name, " tag"}, tag_out, t);
    check({name, " no accept while done"}, in_ready, 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({name, " consumed"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; tag_in = '0;
    flush = 1'b0; out_ready = 1'b0;
    #12;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset result", result, 0);
    check("reset tag_out", tag_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mulhu max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 33);
    run_op("mul max",   3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'h0000_0001, 33);
    run_op("div ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5,  32'h8000_0000, 1);
    run_op("rem ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6,  32'h0000_0000, 1);
    run_op("divu zero", 3'b101, 32'd5,         32'd0,         5'h11, 32'hFFFF_FFFF, 1);
    run_op("remu zero", 3'b111, 32'd7,         32'd0,         5'h1F, 32'h0000_0007, 1);
    run_op("div zero",  3'b100, 32'd7,         32'd0,         5'd7,  32'hFFFF_FFFF, 1);
    run_op("rem zero",  3'b110, 32'hFFFF_FFF9, 32'd0,         5'd8,  32'hFFFF_FFF9, 1);
    run_op("div -7/2",  3'b100, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 33);
    run_op("rem -7/2",  3'b110, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 33);
    run_op("mulhsu",    3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFF, 33);
    run_op("mulh -2*3", 3'b001, 32'hFFFF_FFFE, 32'd3,         5'd12, 32'hFFFF_FFFF, 33);
    run_op("mul -2*3",  3'b000, 32'hFFFF_FFFE, 32'd3,         5'd13, 32'hFFFF_FFFA, 33);
    run_op("mulh min",  3'b001, 32'h8000_0000, 32'h8000_0000, 5'd14, 32'h4000_0000, 33);
    run_op("div 100/-7", 3'b100, 32'd100,      32'hFFFF_FFF9, 5'd15, 32'hFFFF_FFF2, 33);
    run_op("rem 100/-7", 3'b110, 32'd100,      32'hFFFF_FFF9, 5'd16, 32'h0000_0002, 33);
    run_op("divu big",  3'b101, 32'hFFFF_FFFF, 32'd16,        5'd17, 32'h0FFF_FFFF, 33);

    // Backpressure: hold out_ready low while another request is offered
    op = 3'b111; a = 32'd100; b = 32'd7; tag_in = 5'd9; in_valid = 1'b1;
    @(posedge clk);
    #1;
    op = 3'b000; a = 32'd3; b = 32'd3; tag_in = 5'd2;
    seen = 0;
    do begin
      @(negedge clk);
      seen++;
    end while (!out_valid && seen < 80);
    check("bp latency", seen, 33);
    for (int i = 0; i < 5; i++) begin
      check("bp hold", {out_valid, in_ready, result, tag_out}, {1'b1, 1'b0, 32'd2, 5'd9});
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp release", {out_valid, in_ready}, 2'b01);

    // Flush in the 10th BUSY cycle
    op = 3'b101; a = 32'd100; b = 32'd7; tag_in = 5'd20; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("flush busy", {out_valid, in_ready}, 2'b00);
    flush = 1'b1;
    #1;
    check("flush blocks accept", in_ready, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush idle", {out_valid, in_ready}, 2'b01);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flush no result", seen, 0);

    // Reset pulsed mid-BUSY
    op = 3'b000; a = 32'd12345; b = 32'd678; tag_in = 5'd21; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) @(negedge clk);
    check("pre-reset in_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("async reset outputs", {out_valid, in_ready, result, tag_out}, {1'b0, 1'b1, 32'd0, 5'd0});
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    run_op("divu after reset", 3'b101, 32'd100, 32'd7, 5'd22, 32'h0000_000E, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
